dmux1t8_8_buf: RTL
==================

// Module: dmux1t8_8_buf
// PURPOSE
//  Buffered 1-to-8 demultiplexer for 8-bit data; the inverse of the 8-to-1 byte mux element.
//  - Accepts one byte per cycle with a 3-bit destination select.
//  - Parks each byte in a one-entry slot per output channel.
//  - Each channel drains through its own valid/ready handshake.
//  - Sits between a single producer and up to eight consumers in the element library.
// PARAMETERS
//  DW     8   data width per channel
//  CNT_W  16  width of the accepted-byte counter
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      producer has a byte
//  in_ready   out  1      block accepts the byte this cycle
//  in_data    in   DW     byte to route
//  s          in   3      destination channel 0..7
//  out_data   out  8*DW   channel k occupies bits [k*DW +: DW]
//  out_valid  out  8      channel k slot holds a byte
//  out_ready  in   8      consumer k takes its byte this cycle
//  acc_cnt    out  CNT_W  bytes accepted since reset
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-high.
//  - Reset values: out_valid=0, out_data=0, acc_cnt=0.
//    - in_ready is combinational and reads 1 after reset.
//  - Handshakes:
//    - accept = in_valid & in_ready.
//    - drain_k = out_valid[k] & out_ready[k].
//    - in_ready = ~out_valid[s] | out_ready[s]. It depends only on the selected slot.
//  - Producer rule: while in_valid=1 and in_ready=0, hold in_data and s stable.
//  - Latency: a byte accepted at edge N appears with out_valid[s]=1 after edge N. No combinational in->out data path.
//  - Per-slot state machine (two states):
//    - EMPTY -> FULL on accept to k.
//    - FULL -> EMPTY on drain_k without an accept to k.
//    - FULL -> FULL on drain_k and accept to k in the same cycle. The slot reloads and out_valid[k] stays 1.
//    - FULL stays FULL with data unchanged while out_ready[k]=0.
//  - Parallel channels: drains on different channels, and a drain on one channel with an accept to another, all proceed in the same cycle.
//  - out_data of an EMPTY slot holds its last value. Consumers must ignore it.
//  - acc_cnt increments by 1 per accept and wraps 2^CNT_W-1 -> 0.
//  - Reset mid-operation discards all parked bytes. No handshake completes on the reset edge.
//  - s may change freely while in_valid=0.
// CONFIGURATION
//  - Macro DMUX_BCAST_EN adds input port `bcast` (1 bit).
//  - With the macro defined:
//    - bcast=1 makes s a don't-care.
//    - in_ready = &(~out_valid | out_ready).
//    - On accept, all 8 slots load in_data. acc_cnt increments by 1.
//  - Without the macro: no bcast port; unicast behaviour only.
// STRUCTURE
//  - Package dmux_pkg: N_CH=8, SEL_W=3, slot state encoding (S_EMPTY=0, S_FULL=1).
//  - Sub-module dmux_slot: one-entry register slice with valid/ready.
//    - Ports: clk, rst, ld, d, valid, ready, q.
//    - Instantiated 8 times via generate.
//  - Top-level logic: select decode, in_ready, counter.
// TESTING
//  1 Reset, then in_data=0x55 s=3 in_valid=1 for 1 cycle, out_ready=0
//    -> next cycle out_valid=8'h08, out_data[31:24]=0x55, acc_cnt=1.
//  2 Slot 3 full, out_ready[3]=0, send 0xAA s=3
//    -> in_ready=0, slot keeps 0x55. Raise out_ready[3]: same-cycle drain+accept,
//       out_valid[3] stays 1, data becomes 0xAA.
//  3 Send k to s=k for k=0..7 on consecutive cycles, all out_ready=0
//    -> out_valid=8'hFF, each channel holds its index, acc_cnt=8.
//  4 All slots full; out_ready=8'h01 and in s=5
//    -> in_ready=0, channel 0 drains, out_valid=8'hFE.
//  5 Slots 2 and 6 full; assert rst for 1 cycle during in_valid=1
//    -> out_valid=0, acc_cnt=0, no accept counted.
//  6 Preload acc_cnt=0xFFFF by 65535 accepts, one more accept
//    -> acc_cnt=0. With DMUX_BCAST_EN: bcast=1, data 0x3C
//       -> out_valid=8'hFF, all lanes 0x3C, acc_cnt +1.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared constants and slot state encoding for the buffered 1-to-8 byte demultiplexer.
package dmux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/dmux_slot.sv
// One-entry register slice: parks a byte on ld and holds it until the consumer takes it.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] d,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] q
);

  slot_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_next;
  end

  // A drain with a simultaneous reload keeps the slot FULL.
  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (ld) state_next = S_FULL;
      S_FULL:  if (ready && !ld) state_next = S_EMPTY;
      default: state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    valid = (state == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/dmux1t8_8_buf.sv
// Buffered 1-to-8 byte demultiplexer with per-channel valid/ready drains.
// Optional macro DMUX_BCAST_EN adds a bcast input that loads all eight slots at once.
module dmux1t8_8_buf
  import dmux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SEL_W-1:0]   s,
`ifdef DMUX_BCAST_EN
  input  logic               bcast,
`endif
  output logic [N_CH*DW-1:0] out_data,
  output logic [N_CH-1:0]    out_valid,
  input  logic [N_CH-1:0]    out_ready,
  output logic [CNT_W-1:0]   acc_cnt
);

  logic [N_CH-1:0] sel_onehot;
  logic [N_CH-1:0] ld;
  logic            uni_ready;
  logic            accept;

  always_comb begin
    sel_onehot    = '0;
    sel_onehot[s] = 1'b1;
    uni_ready     = ~out_valid[s] | out_ready[s];
  end

  // Broadcast needs every slot free (or draining) before it can accept.
`ifdef DMUX_BCAST_EN
  always_comb begin
    in_ready = bcast ? (&(~out_valid | out_ready)) : uni_ready;
    accept   = in_valid & in_ready;
    ld       = accept ? (bcast ? {N_CH{1'b1}} : sel_onehot) : '0;
  end
`else
  always_comb begin
    in_ready = uni_ready;
    accept   = in_valid & in_ready;
    ld       = accept ? sel_onehot : '0;
  end
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    dmux_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .ld    (ld[k]),
      .d     (in_data),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .q     (out_data[k*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)         acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + 1'b1;
  end

endmodule
